// File: rtl/jtopl_mmrx_if.sv
// rtl/jtopl_mmrx_if.sv - host write bus (strobe, address, data, busy, overflow) for jtopl_mmrx
interface jtopl_mmrx_if;
    logic       write;
    logic [1:0] addr;
    logic [7:0] din;
    logic       busy;
    logic       overflow;

    modport master (output write, addr, din, input busy, overflow);
    modport slave  (input write, addr, din, output busy, overflow);
endinterface

// File: rtl/jtopl_mmrx.sv
// rtl/jtopl_mmrx.sv - OPL register write decoder with busy timing; optional write queue under JTOPL_WRQUEUE_EN
module jtopl_mmrx #(
    parameter int BANKS      = 1,
    parameter int WAV_EN     = 0,
    parameter int ADDR_WAIT  = 4,
    parameter int DATA_WAIT  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen_i,
    jtopl_mmrx_if.slave  host,
    output logic         sel_bank_o,
    output logic [1:0]   sel_group_o,
    output logic [2:0]   sel_sub_o,
    output logic [7:0]   up_o,
    output logic [7:0]   dout_o,
    output logic [7:0]   value_A_o,
    output logic [7:0]   value_B_o,
    output logic         load_A_o,
    output logic         load_B_o,
    output logic         flagen_A_o,
    output logic         flagen_B_o,
    output logic         clr_flag_A_o,
    output logic         clr_flag_B_o,
    output logic         am_dep_o,
    output logic         vib_dep_o,
    output logic         rhy_en_o,
    output logic [4:0]   rhy_kon_o,
    output logic         wave_mode_o,
    output logic         opl3_new_o,
    output logic [5:0]   con4op_o
);
    localparam logic [7:0] ADDR_CNT = 8'(ADDR_WAIT);
    localparam logic [7:0] DATA_CNT = 8'(DATA_WAIT);

    logic [7:0] cnt_q, cnt_d;
    logic       busy;
    logic       acc_vld;
    logic [1:0] acc_addr;
    logic [7:0] acc_din;
    logic       drop;
    logic       idle;
    logic       overflow_q;

    logic [7:0] sel0_q, sel1_q;
    logic       acc_bank, eff_bank;
    logic [7:0] acc_reg;
    logic       acc_sel, acc_data;
    logic       wav_ok;
    logic       ch_hit;
    logic [7:0] dec_up;
    logic [1:0] dec_grp;
    logic [2:0] dec_sub;

    logic [7:0] up_q, dout_q;
    logic       sel_bank_q;
    logic [1:0] sel_group_q;
    logic [2:0] sel_sub_q;
    logic [7:0] value_a_q, value_b_q;
    logic       load_a_q, load_b_q, flagen_a_q, flagen_b_q, clr_a_q, clr_b_q;
    logic       am_dep_q, vib_dep_q, rhy_en_q, wave_mode_q, opl3_new_q;
    logic [4:0] rhy_kon_q;
    logic [5:0] con4op_q;

    assign busy          = cnt_q != 8'd0;
    assign host.busy     = busy;
    assign host.overflow = overflow_q;

`ifdef JTOPL_WRQUEUE_EN
    // FIFO_DEPTH must be a power of two, at least 2
    localparam int QW = $clog2(FIFO_DEPTH);

    logic [9:0]  fifo_q [FIFO_DEPTH];
    logic [QW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, pop, push, to_queue;

    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[QW-1:0] == rd_ptr_q[QW-1:0]) && (wr_ptr_q[QW] != rd_ptr_q[QW]);

    // queue head has priority over a new host write so order is preserved
    always_comb begin
        pop      = !busy && !fifo_empty;
        to_queue = host.write && (busy || !fifo_empty);
        push     = to_queue && (!fifo_full || pop);
        drop     = to_queue && !push;
        acc_vld  = pop || (host.write && !to_queue);
        {acc_addr, acc_din} = pop ? fifo_q[rd_ptr_q[QW-1:0]] : {host.addr, host.din};
        idle     = !busy && fifo_empty;
        wr_ptr_d = wr_ptr_q + {{QW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{QW{1'b0}}, pop};
    end

    // queue storage and pointers; reset empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) fifo_q[wr_ptr_q[QW-1:0]] <= {host.addr, host.din};
        end
    end
`else
    // without the queue a write during busy is simply lost
    always_comb begin
        acc_vld  = host.write && !busy;
        drop     = host.write && busy;
        acc_addr = host.addr;
        acc_din  = host.din;
        idle     = !busy;
    end
`endif

    assign acc_sel  = acc_vld && !acc_addr[0];
    assign acc_data = acc_vld && acc_addr[0];
    assign acc_bank = (BANKS == 2) ? acc_addr[1] : 1'b0;
    assign acc_reg  = acc_bank ? sel1_q : sel0_q;
    // in OPL2-compatible mode bank 1 aliases bank 0, except the mode register itself
    assign eff_bank = acc_bank && (opl3_new_q || acc_reg == 8'h05);
    assign wav_ok   = (WAV_EN != 0) || (BANKS == 2) || wave_mode_q;
    assign ch_hit   = (acc_reg[3:0] <= 4'd8) &&
                      (acc_reg[7:4] == 4'hA || acc_reg[7:4] == 4'hB || acc_reg[7:4] == 4'hC);

    // busy counter: reload on acceptance, count down on cen
    always_comb begin
        cnt_d = cnt_q;
        if (acc_vld)
            cnt_d = acc_addr[0] ? DATA_CNT : ADDR_CNT;
        else if (cen_i && busy)
            cnt_d = cnt_q - 8'd1;
    end

    // decode the selected register into a slot/channel update strobe
    always_comb begin
        dec_up  = 8'h00;
        dec_grp = 2'd0;
        dec_sub = 3'd0;
        if (acc_reg[2:0] <= 3'd5 && acc_reg[4:3] != 2'd3) begin
            dec_grp = acc_reg[4:3];
            dec_sub = acc_reg[2:0];
            case (acc_reg[7:5])
                3'd1:    dec_up = 8'h01;
                3'd2:    dec_up = 8'h02;
                3'd3:    dec_up = 8'h04;
                3'd4:    dec_up = 8'h08;
                3'd7:    dec_up = wav_ok ? 8'h80 : 8'h00;
                default: dec_up = 8'h00;
            endcase
        end
        if (ch_hit) begin
            dec_grp = 2'(acc_reg[3:0] / 4'd3);
            dec_sub = 3'(acc_reg[3:0] % 4'd3);
            case (acc_reg[7:4])
                4'hA:    dec_up = 8'h10;
                4'hB:    dec_up = 8'h20;
                default: dec_up = 8'h40;
            endcase
        end
    end

    // busy counter and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            overflow_q <= drop;
        end
    end

    // per-bank register select latches
    always_ff @(posedge clk) begin
        if (rst) begin
            sel0_q <= 8'd0;
            sel1_q <= 8'd0;
        end else if (acc_sel) begin
            if (acc_bank) sel1_q <= acc_din;
            else          sel0_q <= acc_din;
        end
    end

    // one-clock update strobe with data and target slot/channel
    always_ff @(posedge clk) begin
        if (rst) begin
            up_q        <= 8'h00;
            dout_q      <= 8'h00;
            sel_bank_q  <= 1'b0;
            sel_group_q <= 2'd0;
            sel_sub_q   <= 3'd0;
        end else begin
            up_q <= 8'h00;
            if (acc_data) begin
                up_q        <= dec_up;
                dout_q      <= acc_din;
                sel_bank_q  <= eff_bank;
                sel_group_q <= dec_grp;
                sel_sub_q   <= dec_sub;
            end
        end
    end

    // global control registers; flag clear lasts until an idle cen
    always_ff @(posedge clk) begin
        if (rst) begin
            value_a_q   <= 8'd0;
            value_b_q   <= 8'd0;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            flagen_a_q  <= 1'b1;
            flagen_b_q  <= 1'b1;
            clr_a_q     <= 1'b0;
            clr_b_q     <= 1'b0;
            am_dep_q    <= 1'b0;
            vib_dep_q   <= 1'b0;
            rhy_en_q    <= 1'b0;
            rhy_kon_q   <= 5'd0;
            wave_mode_q <= 1'b0;
            opl3_new_q  <= 1'b0;
            con4op_q    <= 6'd0;
        end else begin
            if (cen_i && idle) begin
                clr_a_q <= 1'b0;
                clr_b_q <= 1'b0;
            end
            if (acc_data && !eff_bank) begin
                case (acc_reg)
                    8'h01: wave_mode_q <= acc_din[5];
                    8'h02: value_a_q   <= acc_din;
                    8'h03: value_b_q   <= acc_din;
                    8'h04: begin
                        flagen_a_q <= ~acc_din[6];
                        flagen_b_q <= ~acc_din[5];
                        load_b_q   <= acc_din[1];
                        load_a_q   <= acc_din[0];
                        clr_a_q    <= acc_din[7];
                        clr_b_q    <= acc_din[7];
                    end
                    8'hBD: begin
                        am_dep_q  <= acc_din[7];
                        vib_dep_q <= acc_din[6];
                        rhy_en_q  <= acc_din[5];
                        rhy_kon_q <= acc_din[4:0];
                    end
                    default: ;
                endcase
            end
            if (acc_data && eff_bank) begin
                case (acc_reg)
                    8'h04:   con4op_q   <= acc_din[5:0];
                    8'h05:   opl3_new_q <= acc_din[0];
                    default: ;
                endcase
            end
        end
    end

    assign up_o         = up_q;
    assign dout_o       = dout_q;
    assign sel_bank_o   = sel_bank_q;
    assign sel_group_o  = sel_group_q;
    assign sel_sub_o    = sel_sub_q;
    assign value_A_o    = value_a_q;
    assign value_B_o    = value_b_q;
    assign load_A_o     = load_a_q;
    assign load_B_o     = load_b_q;
    assign flagen_A_o   = flagen_a_q;
    assign flagen_B_o   = flagen_b_q;
    assign clr_flag_A_o = clr_a_q;
    assign clr_flag_B_o = clr_b_q;
    assign am_dep_o     = am_dep_q;
    assign vib_dep_o    = vib_dep_q;
    assign rhy_en_o     = rhy_en_q;
    assign rhy_kon_o    = rhy_kon_q;
    assign wave_mode_o  = wave_mode_q;
    assign opl3_new_o   = opl3_new_q;
    assign con4op_o     = con4op_q;
endmodule

// File: tb/tb_jtopl_mmrx.sv
// tb/tb_jtopl_mmrx.sv - randomized self-checking bench for jtopl_mmrx (BANKS=2)
`timescale 1ns/1ps
module tb_jtopl_mmrx;
    localparam int AW = 4;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;
    always #5 clk = ~clk;

    jtopl_mmrx_if host();

    logic       sel_bank, load_A, load_B, flagen_A, flagen_B, clr_A, clr_B;
    logic       am_dep, vib_dep, rhy_en, wave_mode, opl3_new;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic [7:0] up, dout, value_A, value_B;
    logic [4:0] rhy_kon;
    logic [5:0] con4op;

    jtopl_mmrx #(.BANKS(2), .WAV_EN(0), .ADDR_WAIT(AW), .DATA_WAIT(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cen_i(cen), .host(host),
        .sel_bank_o(sel_bank), .sel_group_o(sel_group), .sel_sub_o(sel_sub),
        .up_o(up), .dout_o(dout), .value_A_o(value_A), .value_B_o(value_B),
        .load_A_o(load_A), .load_B_o(load_B), .flagen_A_o(flagen_A), .flagen_B_o(flagen_B),
        .clr_flag_A_o(clr_A), .clr_flag_B_o(clr_B), .am_dep_o(am_dep), .vib_dep_o(vib_dep),
        .rhy_en_o(rhy_en), .rhy_kon_o(rhy_kon), .wave_mode_o(wave_mode),
        .opl3_new_o(opl3_new), .con4op_o(con4op)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_sel [2];
    int m_wave, m_va, m_vb, m_fla, m_flb, m_ld, m_clr, m_am, m_vib, m_rhy, m_kon, m_opl3, m_con;

    task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d, input logic c);
        host.write = w;
        host.addr  = a;
        host.din   = d;
        cen        = c;
        @(posedge clk);
        #1;
        host.write = 1'b0;
        cen        = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        logic c;
        n = 0;
        for (int i = 0; i < 400 && host.busy; i++) begin
            c = 1'($urandom % 2);
            step(1'b0, 2'b00, 8'h00, c);
            if (c) n++;
        end
        checks++;
        if (host.busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle timeout: busy=%b required 0", host.busy);
        end
    endtask

    task automatic model_reset();
        m_sel[0] = 0; m_sel[1] = 0;
        m_wave = 0; m_va = 0; m_vb = 0; m_fla = 1; m_flb = 1; m_ld = 0; m_clr = 0;
        m_am = 0; m_vib = 0; m_rhy = 0; m_kon = 0; m_opl3 = 0; m_con = 0;
    endtask

    // what a data write to the currently selected register of bank b should do
    task automatic model_data(input int b, input int d, output int eup, output int egrp,
                              output int esub, output int ebank);
        int r;
        int eb;
        r  = m_sel[b];
        eb = b;
        if (b == 1 && m_opl3 == 0 && r != 5) eb = 0;
        eup = 0; egrp = 0; esub = 0; ebank = eb; m_clr = 0;
        if (((r >= 'h20 && r <= 'h95) || (r >= 'hE0 && r <= 'hF5)) && (r % 8) <= 5 && ((r / 8) % 4) != 3) begin
            egrp = (r / 8) % 4;
            esub = r % 8;
            eup  = (r >= 'hE0) ? 'h80 : (1 << (r / 32 - 1));
        end else if (r >= 'hA0 && r <= 'hC8 && (r % 16) <= 8) begin
            egrp = (r % 16) / 3;
            esub = (r % 16) % 3;
            eup  = 1 << (4 + r / 16 - 'hA);
        end
        if (eb == 0) begin
            case (r)
                1: m_wave = (d >> 5) & 1;
                2: m_va = d;
                3: m_vb = d;
                4: begin
                    m_fla = ((d >> 6) & 1) ^ 1;
                    m_flb = ((d >> 5) & 1) ^ 1;
                    m_ld  = d & 3;
                    m_clr = (d >> 7) & 1;
                end
                'hBD: begin
                    m_am = (d >> 7) & 1; m_vib = (d >> 6) & 1;
                    m_rhy = (d >> 5) & 1; m_kon = d & 31;
                end
                default: ;
            endcase
        end else begin
            case (r)
                4: m_con = d & 63;
                5: m_opl3 = d & 1;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        int n;
        int ups;
        rst = 1'b1;
        step(1'b0, 2'b00, 8'h00, 1'b1);
        step(1'b0, 2'b00, 8'h00, 1'b1);
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", host.busy); end
        checks++; if (up !== 8'h00) begin errors++; $display("FAIL reset_up: got %h want 00", up); end
        checks++;
        if ({flagen_A, flagen_B} !== 2'b11) begin errors++; $display("FAIL reset_flagen: got %b want 11", {flagen_A, flagen_B}); end
        checks++;
        if ({dout, sel_bank, sel_group, sel_sub, value_A, value_B, load_A, load_B, clr_A, clr_B, am_dep, vib_dep,
             rhy_en, rhy_kon, wave_mode, opl3_new, con4op, host.overflow} !== '0) begin
            errors++; $display("FAIL reset_regs: some register nonzero after reset");
        end
        rst = 1'b0;
        // load a write and leave more pending, then reset in the middle of busy
        step(1'b1, 2'b00, 8'h20, 1'b1);
        wait_idle(n);
        step(1'b1, 2'b01, 8'h44, 1'b1);
        step(1'b1, 2'b01, 8'h45, 1'b1);
        step(1'b1, 2'b01, 8'h46, 1'b1);
        rst = 1'b1;
        step(1'b0, 2'b00, 8'h00, 1'b1);
        rst = 1'b0;
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: busy=%b want 0", host.busy); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout: got %h want 00", dout); end
        ups = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 2'b00, 8'h00, 1'b1);
            if (up !== 8'h00 || host.busy !== 1'b0) ups++;
        end
        checks++; if (ups != 0) begin errors++; $display("FAIL rst_discard: %0d activity cycles want 0", ups); end
    endtask

    task automatic test_operator();
        int n;
        step(1'b1, 2'b00, 8'h20, 1'b1);
        checks++; if (host.busy !== 1'b1) begin errors++; $display("FAIL op_busy_set: got %b want 1", host.busy); end
        wait_idle(n);
        checks++; if (n != AW) begin errors++; $display("FAIL addr_wait_len: got %0d want %0d", n, AW); end
        step(1'b1, 2'b01, 8'h21, 1'b1);
        checks++; if (up !== 8'h01) begin errors++; $display("FAIL op_up: got %h want 01", up); end
        checks++;
        if ({dout, sel_bank, sel_group, sel_sub} !== {8'h21, 1'b0, 2'd0, 3'd0}) begin
            errors++; $display("FAIL op_target: got %h/%b/%0d/%0d want 21/0/0/0", dout, sel_bank, sel_group, sel_sub);
        end
        step(1'b0, 2'b00, 8'h00, 1'b1);
        checks++; if (up !== 8'h00) begin errors++; $display("FAIL op_up_pulse: got %h want 00", up); end
        wait_idle(n);
        checks++; if (n != DW - 1) begin errors++; $display("FAIL data_wait_len: got %0d want %0d", n, DW - 1); end
    endtask

    task automatic test_channel();
        int n;
        logic [7:0] d;
        d = 8'($urandom);
        step(1'b1, 2'b00, 8'hA7, 1'b1);
        wait_idle(n);
        step(1'b1, 2'b01, d, 1'b1);
        checks++; if (up !== 8'h10) begin errors++; $display("FAIL ch_up: got %h want 10", up); end
        checks++;
        if ({dout, sel_group, sel_sub} !== {d, 2'd2, 3'd1}) begin
            errors++; $display("FAIL ch_target: got %h/%0d/%0d want %h/2/1", dout, sel_group, sel_sub, d);
        end
        wait_idle(n);
    endtask

    task automatic test_busy_write();
        int n;
        int ovf;
        logic [7:0] got [$];
        step(1'b1, 2'b01, 8'h5A, 1'b1);
        checks++; if (up !== 8'h10) begin errors++; $display("FAIL bw_first_up: got %h want 10", up); end
`ifndef JTOPL_WRQUEUE_EN
        step(1'b1, 2'b01, 8'hC3, 1'b1);
        checks++; if (host.overflow !== 1'b1) begin errors++; $display("FAIL bw_overflow: got %b want 1", host.overflow); end
        checks++;
        if ({up, dout} !== {8'h00, 8'h5A}) begin errors++; $display("FAIL bw_dropped: up/dout %h/%h want 00/5a", up, dout); end
        step(1'b0, 2'b00, 8'h00, 1'b1);
        checks++; if (host.overflow !== 1'b0) begin errors++; $display("FAIL bw_ovf_pulse: got %b want 0", host.overflow); end
        for (int i = 0; i < DW - 3; i++) step(1'b0, 2'b00, 8'h00, 1'b1);
        checks++; if (host.busy !== 1'b1) begin errors++; $display("FAIL bw_last_busy: got %b want 1", host.busy); end
        step(1'b1, 2'b01, 8'h77, 1'b1);
        checks++;
        if ({host.overflow, host.busy, up} !== {1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL bw_edge_reject: ovf/busy/up %b/%b/%h want 1/0/00", host.overflow, host.busy, up);
        end
        step(1'b0, 2'b00, 8'h00, 1'b1);
        checks++;
        if ({up, dout} !== {8'h00, 8'h5A}) begin errors++; $display("FAIL bw_edge_after: up/dout %h/%h want 00/5a", up, dout); end
`else
        ovf = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b01, 8'(8'h80 + i), 1'b1);
            if (host.overflow) ovf++;
        end
        for (int i = 0; i < 5 * (DW + 4) && got.size() < 4; i++) begin
            step(1'b0, 2'b00, 8'h00, 1'b1);
            if (host.overflow) ovf++;
            if (up !== 8'h00) begin
                got.push_back(dout);
                checks++; if (up !== 8'h10) begin errors++; $display("FAIL q_strobe_up: got %h want 10", up); end
            end
        end
        checks++; if (ovf != 1) begin errors++; $display("FAIL q_overflow_count: got %0d want 1", ovf); end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL q_strobe_count: got %0d want 4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'(8'h80 + i)) begin errors++; $display("FAIL q_order[%0d]: got %h want %h", i, got[i], 8'(8'h80 + i)); end
        end
`endif
        wait_idle(n);
    endtask

    task automatic test_banks();
        int n;
        step(1'b1, 2'b10, 8'h40, 1'b1); wait_idle(n);
        step(1'b1, 2'b11, 8'h11, 1'b1);
        checks++;
        if ({up, sel_bank} !== {8'h02, 1'b0}) begin errors++; $display("FAIL bk_opl2_alias: up/bank %h/%b want 02/0", up, sel_bank); end
        wait_idle(n);
        step(1'b1, 2'b10, 8'h05, 1'b1); wait_idle(n);
        step(1'b1, 2'b11, 8'h01, 1'b1);
        checks++;
        if ({up, opl3_new} !== {8'h00, 1'b1}) begin errors++; $display("FAIL bk_opl3_new: up/new %h/%b want 00/1", up, opl3_new); end
        wait_idle(n);
        step(1'b1, 2'b10, 8'h40, 1'b1); wait_idle(n);
        step(1'b1, 2'b11, 8'h3C, 1'b1);
        checks++;
        if ({up, sel_bank, sel_group, sel_sub, dout} !== {8'h02, 1'b1, 2'd0, 3'd0, 8'h3C}) begin
            errors++; $display("FAIL bk1_ksl: up/bank/grp/sub/dout %h/%b/%0d/%0d/%h want 02/1/0/0/3c", up, sel_bank, sel_group, sel_sub, dout);
        end
        wait_idle(n);
        step(1'b1, 2'b10, 8'h04, 1'b1); wait_idle(n);
        step(1'b1, 2'b11, 8'h2A, 1'b1);
        checks++; if (con4op !== 6'h2A) begin errors++; $display("FAIL bk1_con4op: got %h want 2a", con4op); end
        wait_idle(n);
        step(1'b1, 2'b00, 8'h04, 1'b1); wait_idle(n);
        step(1'b1, 2'b01, 8'h80, 1'b1);
        checks++;
        if ({clr_A, clr_B, flagen_A, flagen_B, load_A, load_B} !== 6'b111100) begin
            errors++; $display("FAIL clr_set: clr/flagen/load %b%b/%b%b/%b%b want 11/11/00", clr_A, clr_B, flagen_A, flagen_B, load_A, load_B);
        end
        for (int i = 0; i < 200 && host.busy; i++) step(1'b0, 2'b00, 8'h00, 1'b1);
        checks++;
        if ({host.busy, clr_A, clr_B} !== 3'b011) begin errors++; $display("FAIL clr_hold: busy/clr %b/%b%b want 0/11", host.busy, clr_A, clr_B); end
        step(1'b0, 2'b00, 8'h00, 1'b1);
        checks++;
        if ({clr_A, clr_B} !== 2'b00) begin errors++; $display("FAIL clr_release: got %b%b want 00", clr_A, clr_B); end
    endtask

    task automatic test_random();
        int n, b, r, d, eup, egrp, esub, ebank;
        logic [35:0] eg, ag;
        rst = 1'b1;
        step(1'b0, 2'b00, 8'h00, 1'b1);
        rst = 1'b0;
        model_reset();
        for (int it = 0; it < 40; it++) begin
            b = $urandom % 2;
            case ($urandom % 3)
                0: r = $urandom % 256;
                1: case ($urandom % 7)
                       0: r = 'h01; 1: r = 'h02; 2: r = 'h03; 3: r = 'h04;
                       4: r = 'h05; 5: r = 'hBD; default: r = 'hE3;
                   endcase
                default: r = ($urandom % 2) ? ('h20 + $urandom % 'h76) : ('hA0 + $urandom % 'h29);
            endcase
            d = $urandom % 256;
            step(1'b1, {1'(b), 1'b0}, 8'(r), 1'b1);
            m_sel[b] = r;
            wait_idle(n);
            checks++; if (n != AW) begin errors++; $display("FAIL rnd_addr_wait: got %0d want %0d", n, AW); end
            step(1'b0, 2'b00, 8'h00, 1'b1);
            step(1'b1, {1'(b), 1'b1}, 8'(d), 1'b1);
            model_data(b, d, eup, egrp, esub, ebank);
            checks++;
            if (up !== 8'(eup)) begin errors++; $display("FAIL rnd_up: bank %0d reg %h got %h want %h", b, r, up, 8'(eup)); end
            if (eup != 0) begin
                checks++;
                if ({dout, sel_bank, sel_group, sel_sub} !== {8'(d), 1'(ebank), 2'(egrp), 3'(esub)}) begin
                    errors++;
                    $display("FAIL rnd_target: reg %h got %h/%b/%0d/%0d want %h/%0d/%0d/%0d", r, dout, sel_bank, sel_group, sel_sub, 8'(d), ebank, egrp, esub);
                end
            end
            checks++;
            if ({clr_A, clr_B} !== {2{1'(m_clr)}}) begin errors++; $display("FAIL rnd_clr: reg %h got %b%b want %0d", r, clr_A, clr_B, m_clr); end
            eg = {m_va[7:0], m_vb[7:0], m_fla[0], m_flb[0], m_ld[0], m_ld[1], m_am[0], m_vib[0], m_rhy[0],
                  m_kon[4:0], m_wave[0], m_opl3[0], m_con[5:0]};
            ag = {value_A, value_B, flagen_A, flagen_B, load_A, load_B, am_dep, vib_dep, rhy_en,
                  rhy_kon, wave_mode, opl3_new, con4op};
            checks++;
            if (ag !== eg) begin errors++; $display("FAIL rnd_globals: bank %0d reg %h data %h got %h want %h", b, r, d, ag, eg); end
            wait_idle(n);
            checks++; if (n != DW) begin errors++; $display("FAIL rnd_data_wait: got %0d want %0d", n, DW); end
            step(1'b0, 2'b00, 8'h00, 1'b1);
        end
    endtask

    initial begin
        host.write = 1'b0;
        host.addr  = 2'b00;
        host.din   = 8'h00;
        test_reset();
        test_operator();
        test_channel();
        test_busy_write();
        test_banks();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtopl_mmrx.md
JTOPL_MMRX -- requirements
Module: jtopl_mmrx

Interface
REQ-001 SHALL have parameter BANKS, default 1, number of register banks (1 = OPL/OPL2, 2 = OPL3).
REQ-002 SHALL have parameter WAV_EN, default 0, 1 = waveform registers 0xE0-0xF5 always writable.
REQ-003 SHALL have parameter ADDR_WAIT, default 4, busy length in cen ticks after an address write.
REQ-004 SHALL have parameter DATA_WAIT, default 24, busy length in cen ticks after a data write.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, write-queue depth (power of two), used only with REQ-033.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-008 SHALL have port cen, input, 1, operator clock enable.
REQ-009 SHALL have port write, input, 1, host write strobe, one clk per access.
REQ-010 SHALL have port addr, input, 2; bit0 0=address/1=data; bit1 bank, ignored when BANKS=1.
REQ-011 SHALL have port din, input, 8, host data.
REQ-012 SHALL have port busy, output, 1, write-wait status.
REQ-013 SHALL have port overflow, output, 1, one-clk pulse on each dropped write.
REQ-014 SHALL have port sel_bank/sel_group/sel_sub, output, 1/2/3, target slot or channel of the current update.
REQ-015 SHALL have port up, output, 8, one-hot update strobe {wav,fbcon,fnumhi,fnumlo,sl_rr,ar_dr,ksl_tl,mult}.
REQ-016 SHALL have port dout, output, 8, data byte valid with up.
REQ-017 SHALL have ports value_A, value_B (8), load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B (1), outputs, timer controls.
REQ-018 SHALL have ports am_dep, vib_dep, rhy_en (1), rhy_kon (5), wave_mode, opl3_new (1), con4op (6), outputs, global controls.

Function
REQ-019 SHALL latch din into selreg[bank] on an accepted address write; bank 1 selreg exists only when BANKS=2.
REQ-020 SHALL accept a write only when busy=0 at that clk edge; writes with busy=1 are handled per REQ-033.
REQ-021 SHALL reload the busy counter with ADDR_WAIT or DATA_WAIT on acceptance, decrement on cen, and set busy = counter!=0.
REQ-022 SHALL reject a write arriving in the same cycle the counter reaches zero (busy sampled pre-edge).
REQ-023 SHALL, one clk after an accepted data write, assert exactly one up bit for one clk with dout=din, sel_bank=bank, or none if the address decodes to no slot/channel register.
REQ-024 SHALL decode operator registers 0x20-0x95 and 0xE0-0xF5 with [2:0]<=5, [4:3]!=3: sel_group=[4:3], sel_sub=[2:0]; [7:5]=1..4 map to mult, ksl_tl, ar_dr, sl_rr.
REQ-025 SHALL assert up.wav only if WAV_EN=1, BANKS=2 or wave_mode=1.
REQ-026 SHALL decode channel registers 0xA0-0xC8 with [3:0]<=8: group=[3:0]/3, sub=[3:0] mod 3.
REQ-027 SHALL decode bank-0 globals: 0x01 bit5 -> wave_mode; 0x02 -> value_A; 0x03 -> value_B; 0x04 -> flagen_A=~d6, flagen_B=~d5, {load_B,load_A}=d[1:0], clr_flag_A/B=d7; 0xBD -> am_dep, vib_dep, rhy_en, rhy_kon.
REQ-028 SHALL, when BANKS=2, decode bank-1 0x104 -> con4op=d[5:0] and 0x105 -> opl3_new=d0; bank-1 0x01-0x08 and 0xBD are ignored.
REQ-029 SHALL hold clr_flag_A/B high until the first cen with no write in progress, then clear them.
REQ-030 SHALL, when opl3_new=0 and BANKS=2, treat bank-1 data writes as bank 0 except 0x105.

Reset
REQ-031 SHALL on rst clear selreg, counter, busy, up, overflow, dout, sel_*, value_*, load_*, clr_flag_*, am_dep, vib_dep, rhy_en, rhy_kon, wave_mode, opl3_new, con4op; set flagen_A=flagen_B=1.
REQ-032 SHALL on rst mid-busy or mid-queue discard all pending writes and deassert busy the next cycle.

Configuration
REQ-033 SHALL, with JTOPL_WRQUEUE_EN defined, queue writes arriving while busy in a FIFO_DEPTH FIFO of {addr,din}, pop one per cycle when busy=0 as an accepted write, and pulse overflow only when full; without the macro, SHALL drop busy writes, pulse overflow, and have no FIFO.

Verification
REQ-034 SHALL cover: write addr 0x20, data 0x21, busy clear -> up=0x01 one clk, dout=0x21, group 0, sub 0.
REQ-035 SHALL cover: addr 0xA7 then data -> up.fnumlo, sel_group=2, sel_sub=1.
REQ-036 SHALL cover: data write during busy, macro undefined -> overflow pulse, no up, registers unchanged.
REQ-037 SHALL cover: macro defined, 5 writes during busy with FIFO_DEPTH=4 -> one overflow, four strobes in order after busy falls.
REQ-038 SHALL cover: BANKS=2, bank1 0x105=1 then bank1 0x40 -> up.ksl_tl with sel_bank=1; 0x04=0x80 -> clr_flag_A/B high until next idle cen.
